// File: rtl/instr_fetch.sv
// instr_fetch: program counter plus memory read sequencer feeding the cpu
// execute block through a valid/acknowledge handshake. It accepts branch
// redirects from the cpu and stops fetching once a HLT word is consumed.
module instr_fetch #(
    parameter int unsigned     ADDRW    = 12,
    parameter logic [ADDRW-1:0] RESET_PC = '0,
    parameter logic [3:0]      HLT      = 4'b1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mutexLow,
    output logic [ADDRW-1:0] MemAddr,
    output logic             MemRen,
    input  logic [31:0]      MemDataIn,
    input  logic             MemReady,
    output logic [31:0]      IReg,
    output logic             IValid,
    input  logic             IAck,
    input  logic             BraTaken,
    input  logic [ADDRW-1:0] BraTarget,
    output logic             Halted
);

    localparam int unsigned DATAW = 32;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDRW-1:0]   pc_q, pc_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic               ren_q, ren_d;
    logic [DATAW-1:0]   ireg_q, ireg_d;
    logic               ivalid_q, ivalid_d;
    logic               halted_q, halted_d;
    logic               pend_q, pend_d;
    logic [ADDRW-1:0]   tgt_q, tgt_d;

    assign MemAddr = addr_q;
    assign MemRen  = ren_q;
    assign IReg    = ireg_q;
    assign IValid  = ivalid_q;
    assign Halted  = halted_q;

    // Next-state and registered-output logic for the fetch sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        ren_d    = ren_q;
        ireg_d   = ireg_q;
        ivalid_d = ivalid_q;
        halted_d = halted_q;
        pend_d   = pend_q;
        tgt_d    = tgt_q;

        case (state_q)
            S_FETCH: begin
                ren_d = 1'b0;
                if (BraTaken) begin
                    pc_d = BraTarget;
                end else if (mutexLow) begin
                    ren_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MemReady) begin
                    ren_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_FETCH;
                    if (BraTaken) begin
                        pc_d = BraTarget;
                    end else if (pend_q) begin
                        pc_d = tgt_q;
                    end else begin
                        ireg_d   = MemDataIn;
                        ivalid_d = 1'b1;
                        pc_d     = pc_q + ADDRW'(1);
                        state_d  = S_HOLD;
                    end
                end else if (BraTaken) begin
                    // Read cannot be cancelled; remember where to go once it lands.
                    pend_d = 1'b1;
                    tgt_d  = BraTarget;
                end
            end
            S_HOLD: begin
                if (BraTaken) begin
                    ivalid_d = 1'b0;
                    pc_d     = BraTarget;
                    state_d  = S_FETCH;
                end else if (IAck) begin
                    ivalid_d = 1'b0;
                    if (ireg_q[DATAW-1 -: 4] == HLT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                ren_d    = 1'b0;
                ivalid_d = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            ren_q    <= 1'b0;
            ireg_q   <= '0;
            ivalid_q <= 1'b0;
            halted_q <= 1'b0;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ren_q    <= ren_d;
            ireg_q   <= ireg_d;
            ivalid_q <= ivalid_d;
            halted_q <= halted_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch;

    localparam int unsigned ADDRW = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             mutexLow;
    logic [ADDRW-1:0] MemAddr;
    logic             MemRen;
    logic [31:0]      MemDataIn;
    logic             MemReady;
    logic [31:0]      IReg;
    logic             IValid;
    logic             IAck;
    logic             BraTaken;
    logic [ADDRW-1:0] BraTarget;
    logic             Halted;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDRW   (ADDRW),
        .RESET_PC(12'h000),
        .HLT     (4'b1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mutexLow (mutexLow),
        .MemAddr  (MemAddr),
        .MemRen   (MemRen),
        .MemDataIn(MemDataIn),
        .MemReady (MemReady),
        .IReg     (IReg),
        .IValid   (IValid),
        .IAck     (IAck),
        .BraTaken (BraTaken),
        .BraTarget(BraTarget),
        .Halted   (Halted)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    // Behavioural model: what the fetch stage is doing, in plain terms.
    int          m_pc;       // next word address to fetch
    int          m_addr;     // address last put on the bus
    bit          m_reading;  // a read is outstanding
    bit          m_have;     // an instruction is waiting for the cpu
    bit          m_halt;
    bit          m_redirect; // branch arrived while a read was outstanding
    int          m_target;
    logic [31:0] m_word;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pc = 0; m_addr = 0; m_reading = 0; m_have = 0;
            m_halt = 0; m_redirect = 0; m_target = 0; m_word = 0;
        end else if (m_halt) begin
            // only reset gets out of halt
        end else if (m_have) begin
            if (BraTaken) begin
                m_have = 0;
                m_pc   = int'(BraTarget);
            end else if (IAck) begin
                m_have = 0;
                if (m_word[31:28] == 4'b1000) m_halt = 1;
            end
        end else if (m_reading) begin
            if (MemReady) begin
                m_reading = 0;
                if (BraTaken) m_pc = int'(BraTarget);
                else if (m_redirect) m_pc = m_target;
                else begin
                    m_word = MemDataIn;
                    m_have = 1;
                    m_pc   = (m_pc + 1) % 4096;
                end
                m_redirect = 0;
            end else if (BraTaken) begin
                m_redirect = 1;
                m_target   = int'(BraTarget);
            end
        end else begin
            if (BraTaken) m_pc = int'(BraTarget);
            else if (mutexLow) begin
                m_reading = 1;
                m_addr    = m_pc;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(input bit r, input bit mx, input bit rdy, input bit ack,
                       input bit bt, input logic [ADDRW-1:0] btg, input logic [31:0] din);
        reset = r; mutexLow = mx; MemReady = rdy; IAck = ack;
        BraTaken = bt; BraTarget = btg; MemDataIn = din;
        tick();
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("MemRen", 32'(MemRen), 32'(m_reading));
            chk("MemAddr", 32'(MemAddr), 32'(m_addr));
            chk("IValid", 32'(IValid), 32'(m_have));
            chk("IReg", IReg, m_word);
            chk("Halted", 32'(Halted), 32'(m_halt));
        end
    end

    initial begin
        reset = 1'b1; mutexLow = 1'b0; MemReady = 1'b0; IAck = 1'b0;
        BraTaken = 1'b0; BraTarget = '0; MemDataIn = '0;

        // Reset values
        cyc(1, 0, 0, 0, 0, 12'h0, 32'h0);
        started = 1'b1;
        chk("rst_MemRen", 32'(MemRen), 32'd0);
        chk("rst_IValid", 32'(IValid), 32'd0);
        chk("rst_IReg", IReg, 32'd0);
        chk("rst_Halted", 32'(Halted), 32'd0);
        chk("rst_MemAddr", 32'(MemAddr), 32'd0);

        // mutexLow held low: nothing happens
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 12'h0, 32'h0);
            chk("idle_MemRen", 32'(MemRen), 32'd0);
            chk("idle_IValid", 32'(IValid), 32'd0);
        end

        // Two sequential fetches, ready one cycle after request
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("f1_MemRen", 32'(MemRen), 32'd1);
        chk("f1_MemAddr", 32'(MemAddr), 32'h000);
        chk("f1_IValid_early", 32'(IValid), 32'd0);
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h5000_0001);
        chk("f1_IValid", 32'(IValid), 32'd1);
        chk("f1_IReg", IReg, 32'h5000_0001);
        chk("f1_MemRen_drop", 32'(MemRen), 32'd0);
        cyc(0, 0, 0, 1, 0, 12'h0, 32'h0);
        chk("f1_ack", 32'(IValid), 32'd0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("f2_MemAddr", 32'(MemAddr), 32'h001);
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h1000_0002);
        chk("f2_IReg", IReg, 32'h1000_0002);
        cyc(0, 0, 0, 1, 0, 12'h0, 32'h0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("f3_MemAddr", 32'(MemAddr), 32'h002);

        // HLT fetched and consumed
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h8000_0000);
        chk("hlt_IValid", 32'(IValid), 32'd1);
        cyc(0, 0, 0, 1, 0, 12'h0, 32'h0);
        chk("hlt_Halted", 32'(Halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 1, 12'h055, 32'h0);
            chk("hlt_MemRen", 32'(MemRen), 32'd0);
            chk("hlt_stays", 32'(Halted), 32'd1);
        end
        cyc(1, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("hlt_rst_Halted", 32'(Halted), 32'd0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("hlt_resume_MemRen", 32'(MemRen), 32'd1);
        chk("hlt_resume_MemAddr", 32'(MemAddr), 32'h000);

        // Branch during WAIT with late ready: word discarded
        cyc(0, 0, 0, 0, 1, 12'h040, 32'h0);
        cyc(0, 0, 0, 0, 0, 12'h0, 32'h0);
        cyc(0, 0, 0, 0, 0, 12'h0, 32'h0);
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h1234_5678);
        chk("bw_IValid", 32'(IValid), 32'd0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("bw_IValid2", 32'(IValid), 32'd0);
        chk("bw_MemAddr", 32'(MemAddr), 32'h040);

        // Branch in HOLD together with IAck
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h2000_0003);
        chk("bh_IValid", 32'(IValid), 32'd1);
        cyc(0, 0, 0, 1, 1, 12'h010, 32'h0);
        chk("bh_IValid_drop", 32'(IValid), 32'd0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("bh_MemAddr", 32'(MemAddr), 32'h010);

        // PC wraps from 0xFFF to 0x000
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h3000_0000);
        cyc(0, 0, 0, 1, 0, 12'h0, 32'h0);
        cyc(0, 0, 0, 0, 1, 12'hFFF, 32'h0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("wrap_MemAddr_fff", 32'(MemAddr), 32'hFFF);
        cyc(0, 0, 1, 0, 0, 12'h0, 32'h3000_0004);
        cyc(0, 0, 0, 1, 0, 12'h0, 32'h0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("wrap_MemAddr_000", 32'(MemAddr), 32'h000);

        // Reset in WAIT with MemReady in the same cycle
        cyc(1, 0, 1, 0, 0, 12'h0, 32'h4000_0005);
        chk("rw_IValid", 32'(IValid), 32'd0);
        chk("rw_IReg", IReg, 32'd0);
        chk("rw_MemRen", 32'(MemRen), 32'd0);
        cyc(0, 1, 0, 0, 0, 12'h0, 32'h0);
        chk("rw_MemAddr", 32'(MemAddr), 32'h000);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 4000; i++) begin
            bit r, mx, rdy, ack, bt;
            logic [31:0] din;
            r   = Halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
            mx  = ($urandom_range(0, 9) < 7);
            rdy = MemRen ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            ack = IValid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            bt  = ($urandom_range(0, 99) < 8);
            din = {(($urandom_range(0, 9) == 0) ? 4'h8 : 4'($urandom)), 28'($urandom)};
            cyc(r, mx, rdy, ack, bt, ADDRW'($urandom), din);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
